// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// command-master state encoding.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } cmd_state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one local command at a time into a single-beat
// AXI4-Lite write or read and returns the data/RESP on a valid/ready port.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,

  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_write,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,

  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,

  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  cmd_state_e                        state, state_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic                              write_q;
  logic                              aw_done, w_done;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q;
  axi_resp_e                         resp_q;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  // Handshakes are derived from state rather than the VALID outputs so that
  // the outputs stay purely combinational from the registered state.
  assign cmd_hs = (state == IDLE) && cmd_valid;
  assign aw_hs  = (state == WR_REQ) && !aw_done && M_AXI_AWREADY;
  assign w_hs   = (state == WR_REQ) && !w_done && M_AXI_WREADY;
  assign b_hs   = (state == WR_RESP) && M_AXI_BVALID;
  assign ar_hs  = (state == RD_REQ) && M_AXI_ARREADY;
  assign r_hs   = (state == RD_RESP) && M_AXI_RVALID;
  assign rsp_hs = (state == RSP) && rsp_ready;

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;

  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_write = write_q;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_hs) state_next = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (b_hs) state_next = RSP;
      end
      RD_REQ: begin
        M_AXI_ARVALID = 1'b1;
        if (ar_hs) state_next = RD_RESP;
      end
      RD_RESP: begin
        M_AXI_RREADY = 1'b1;
        if (r_hs) state_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture, per-channel write completion and response capture.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= OKAY;
    end else begin
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= axi_resp_e'(M_AXI_BRESP);
      end
      if (r_hs) begin
        rdata_q <= M_AXI_RDATA;
        resp_q  <= axi_resp_e'(M_AXI_RRESP);
      end
    end
  end

endmodule
